// File: rtl/axi_hp_burst_writer_pkg.sv
// Shared AXI3 constants and W-channel state type
// for the HP-port burst writer.
package axi_hp_burst_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned DEF_BURST_LEN = 16;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } w_state_e;

endpackage

// File: rtl/axi_hp_burst_writer_sync_fifo.sv
// Single-clock FIFO with registered storage and count;
// a push into a full FIFO is dropped unless a pop frees the slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_hp_burst_writer.sv
// Buffers burst addresses and data beats into an AXI3 write master.
// AXI_HP_BURST_WRITER_STATS_EN adds burst/drop/high-water counters.
module axi_hp_burst_writer
  import axi_hp_burst_writer_pkg::*;
#(
  parameter int unsigned DATA_DEPTH      = 64,
  parameter int unsigned ADDR_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned BURST_LEN       = DEF_BURST_LEN
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] addr_in,
  input  logic        addr_in_valid,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        overflow,
  output logic        bresp_err,
  output logic        idle
`ifdef AXI_HP_BURST_WRITER_STATS_EN
  ,
  output logic [31:0] stat_bursts,
  output logic [31:0] stat_dropped_words,
  output logic [31:0] stat_max_fill
`endif
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned DCW = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned ACW = $clog2(ADDR_DEPTH) + 1;

  localparam logic [OW-1:0]  OS_MAX      = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]  OS_ONE      = OW'(1);
  localparam logic [DCW-1:0] BURST_WORDS = DCW'(BURST_LEN);
  localparam logic [3:0]     LAST_BEAT   = 4'(BURST_LEN - 1);

  logic [31:0]    a_head;
  logic           a_full, a_empty, a_drop;
  logic [ACW-1:0] a_count;
  logic [63:0]    d_head;
  logic           d_full, d_empty, d_drop;
  logic [DCW-1:0] d_count;

  logic           aw_hs, w_hs, w_start, b_dec;
  w_state_e       w_state_q, w_state_d;
  logic [3:0]     beat_q, beat_d;
  logic [OW-1:0]  out_q, out_d;
  logic [OW-1:0]  grant_q, grant_d;
  logic           overflow_q, bresp_err_q;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(ADDR_DEPTH)
  ) u_addr_fifo (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .push_i (addr_in_valid),
    .din_i  (addr_in),
    .pop_i  (aw_hs),
    .dout_o (a_head),
    .full_o (a_full),
    .empty_o(a_empty),
    .count_o(a_count),
    .drop_o (a_drop)
  );

  sync_fifo #(
    .WIDTH(64),
    .DEPTH(DATA_DEPTH)
  ) u_data_fifo (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .push_i (data_in_valid),
    .din_i  (data_in),
    .pop_i  (w_hs),
    .dout_o (d_head),
    .full_o (d_full),
    .empty_o(d_empty),
    .count_o(d_count),
    .drop_o (d_drop)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, a_full, a_count, d_full};

  assign m_awvalid = !a_empty && (out_q < OS_MAX);
  assign m_awaddr  = a_head;
  assign m_awlen   = LAST_BEAT;
  assign m_awsize  = AXI_SIZE_8B;
  assign m_awburst = AXI_BURST_INCR;
  assign m_wdata   = d_head;
  assign m_wstrb   = 8'hFF;
  assign m_bready  = 1'b1;

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  // An unsolicited B must not wrap the counter and stall AW forever.
  assign b_dec = m_bvalid && (out_q != '0);

  assign overflow  = overflow_q;
  assign bresp_err = bresp_err_q;
  assign idle = a_empty && d_empty && (w_state_q == W_IDLE) && (out_q == '0);

  // A burst starts only with a granted address and a full burst buffered.
  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    w_start   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if ((grant_q != '0) && (d_count >= BURST_WORDS)) begin
          w_start   = 1'b1;
          w_state_d = W_BURST;
        end
      end
      W_BURST: begin
        m_wvalid = 1'b1;
        m_wlast  = (beat_q == LAST_BEAT);
        if (m_wready) begin
          if (m_wlast) begin
            beat_d    = '0;
            w_state_d = W_IDLE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case ({aw_hs, b_dec})
      2'b10:   out_d = out_q + OS_ONE;
      2'b01:   out_d = out_q - OS_ONE;
      default: out_d = out_q;
    endcase
    grant_d = grant_q;
    unique case ({aw_hs, w_start})
      2'b10:   grant_d = grant_q + OS_ONE;
      2'b01:   grant_d = grant_q - OS_ONE;
      default: grant_d = grant_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      w_state_q   <= W_IDLE;
      beat_q      <= '0;
      out_q       <= '0;
      grant_q     <= '0;
      overflow_q  <= 1'b0;
      bresp_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      beat_q    <= beat_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      if (a_drop || d_drop) overflow_q <= 1'b1;
      if (m_bvalid && (m_bresp != AXI_RESP_OKAY)) bresp_err_q <= 1'b1;
    end
  end

`ifdef AXI_HP_BURST_WRITER_STATS_EN
  logic [31:0] bursts_q, dropped_q, max_fill_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bursts_q   <= '0;
      dropped_q  <= '0;
      max_fill_q <= '0;
    end else begin
      if (m_bvalid) bursts_q <= bursts_q + 32'd1;
      if (d_drop) dropped_q <= dropped_q + 32'd1;
      if (32'(d_count) > max_fill_q) max_fill_q <= 32'(d_count);
    end
  end

  assign stat_bursts        = bursts_q;
  assign stat_dropped_words = dropped_q;
  assign stat_max_fill      = max_fill_q;
`endif

endmodule

// File: tb/tb_axi_hp_burst_writer.sv
// Scoreboard bench for axi_hp_burst_writer: expected AW/W traffic
// is queued at stimulus time and checked as the master emits it.
`timescale 1ns/1ps
module tb_axi_hp_burst_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] addr_in = '0;
  logic        addr_in_valid = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic        overflow;
  logic        bresp_err;
  logic        idle;
`ifdef AXI_HP_BURST_WRITER_STATS_EN
  logic [31:0] stat_bursts, stat_dropped_words, stat_max_fill;
`endif

  axi_hp_burst_writer #(
    .DATA_DEPTH(64),
    .ADDR_DEPTH(16),
    .MAX_OUTSTANDING(8),
    .BURST_LEN(16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .addr_in      (addr_in),
    .addr_in_valid(addr_in_valid),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .m_awaddr     (m_awaddr),
    .m_awlen      (m_awlen),
    .m_awsize     (m_awsize),
    .m_awburst    (m_awburst),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_wlast      (m_wlast),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_bresp      (m_bresp),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .overflow     (overflow),
    .bresp_err    (bresp_err),
    .idle         (idle)
`ifdef AXI_HP_BURST_WRITER_STATS_EN
    ,
    .stat_bursts       (stat_bursts),
    .stat_dropped_words(stat_dropped_words),
    .stat_max_fill     (stat_max_fill)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] exp_aw[$];
  logic [63:0] exp_w[$];
  int aw_cyc[$];
  int b_cyc[$];
  int aw_cnt = 0;
  int w_beats = 0;
  int wlast_cnt = 0;
  int b_seen = 0;
  int b_given = 0;
  int b_en = 1;
  int b_err_idx = -1;

  // One clock: check outputs at negedge, then act as the B responder.
  task automatic tick();
    logic [63:0] ed;
    logic [31:0] ea;
    int bi;
    @(negedge sys_clk);
    if (sys_rst) begin
      exp_aw.delete();
      exp_w.delete();
      aw_cnt = 0;
      w_beats = 0;
      wlast_cnt = 0;
      b_seen = 0;
    end else begin
      if (m_wvalid && m_wready) begin
        bi = w_beats % 16;
        vectors++;
        if (exp_w.size() == 0) begin
          miscompares++;
          $display("FAIL w_extra: wdata=%h, required no beat", m_wdata);
        end else begin
          ed = exp_w.pop_front();
          if (m_wdata !== ed) begin
            miscompares++;
            $display("FAIL w_data: got %h, required %h", m_wdata, ed);
          end
        end
        vectors++;
        if (m_wlast !== 1'(bi == 15)) begin
          miscompares++;
          $display("FAIL w_last: beat %0d got %b, required %b",
                   bi, m_wlast, bi == 15);
        end
        vectors++;
        if (m_wstrb !== 8'hFF) begin
          miscompares++;
          $display("FAIL w_strb: got %h, required ff", m_wstrb);
        end
        if (bi == 0) begin
          vectors++;
          if (aw_cnt <= wlast_cnt) begin
            miscompares++;
            $display("FAIL w_before_aw: aw_count=%0d, required >%0d",
                     aw_cnt, wlast_cnt);
          end
        end
        w_beats++;
        if (bi == 15) wlast_cnt++;
      end
      if (m_awvalid && m_awready) begin
        vectors++;
        if (exp_aw.size() == 0) begin
          miscompares++;
          $display("FAIL aw_extra: awaddr=%h, required no AW", m_awaddr);
        end else begin
          ea = exp_aw.pop_front();
          if (m_awaddr !== ea) begin
            miscompares++;
            $display("FAIL aw_addr: got %h, required %h", m_awaddr, ea);
          end
        end
        vectors++;
        if ({m_awlen, m_awsize, m_awburst} !== {4'hF, 3'b011, 2'b01}) begin
          miscompares++;
          $display("FAIL aw_attr: len=%h size=%b burst=%b, required f 011 01",
                   m_awlen, m_awsize, m_awburst);
        end
        aw_cnt++;
        aw_cyc.push_back(cyc);
      end
      if (m_bvalid && m_bready) begin
        b_seen++;
        b_cyc.push_back(cyc);
      end
    end
    @(posedge sys_clk);
    cyc++;
    #1;
    if (sys_rst) begin
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
      b_given = 0;
    end else if (m_bvalid) begin
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
    end else if (b_en != 0 && wlast_cnt > b_given) begin
      m_bvalid = 1'b1;
      m_bresp = (b_given == b_err_idx) ? 2'b10 : 2'b00;
      b_given++;
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] a,
                       input logic dv, input logic [63:0] d,
                       input logic keep);
    addr_in_valid = av;
    addr_in = a;
    data_in_valid = dv;
    data_in = d;
    if (av) exp_aw.push_back(a);
    if (dv && keep) exp_w.push_back(d);
    tick();
    addr_in_valid = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [63:0] base);
    for (int i = 0; i < 16; i++)
      drive(i == 0, a, 1'b1, base + 64'(i), 1'b1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_done(input int nb, input string nm);
    int n = 0;
    while (!(b_seen >= nb && idle === 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL %s_timeout: b_seen=%0d idle=%b, required %0d and 1",
               nm, b_seen, idle, nb);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (m_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_awvalid: got %b, required 0", m_awvalid);
    end
    vectors++;
    if (m_wvalid !== 1'b0 || m_wlast !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_w: wvalid=%b wlast=%b, required 0 0",
               m_wvalid, m_wlast);
    end
    vectors++;
    if (overflow !== 1'b0 || bresp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flags: ovf=%b berr=%b, required 0 0",
               overflow, bresp_err);
    end
    vectors++;
    if (m_bready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_bready: got %b, required 1", m_bready);
    end
    sys_rst = 1'b0;
    tick();
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_idle: got %b, required 1", idle);
    end
  endtask

  task automatic test_basic_burst(input logic [31:0] a,
                                  input logic [63:0] base, input string nm);
    int aw0 = aw_cnt;
    int wl0 = wlast_cnt;
    int wb0 = w_beats;
    int nb = b_seen;
    m_awready = 1'b1;
    m_wready = 1'b1;
    b_en = 1;
    push_burst(a, base);
    wait_done(nb + 1, nm);
    vectors++;
    if (aw_cnt - aw0 != 1 || wlast_cnt - wl0 != 1) begin
      miscompares++;
      $display("FAIL %s_counts: aw=%0d wlast=%0d, required 1 1",
               nm, aw_cnt - aw0, wlast_cnt - wl0);
    end
    vectors++;
    if (w_beats - wb0 != 16) begin
      miscompares++;
      $display("FAIL %s_beats: got %0d, required 16", nm, w_beats - wb0);
    end
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle: got %b, required 1", nm, idle);
    end
  endtask

  task automatic test_backpressure();
    int aw0 = aw_cnt;
    int wl0 = wlast_cnt;
    int nb = b_seen;
    int n = 0;
    b_en = 1;
    m_wready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      m_awready = (i >= 10);
      m_wready = ~m_wready;
      drive(i % 16 == 0, 32'h0F90_0000 + 32'(i * 8),
            1'b1, 64'hB000_0000 + 64'(i), 1'b1);
    end
    while (!(b_seen >= nb + 3 && idle === 1'b1) && n < 1000) begin
      m_wready = ~m_wready;
      tick();
      n++;
    end
    m_wready = 1'b1;
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL bp_timeout: b_seen=%0d, required %0d", b_seen, nb + 3);
    end
    vectors++;
    if (wlast_cnt - wl0 != 3 || aw_cnt - aw0 != 3) begin
      miscompares++;
      $display("FAIL bp_counts: wlast=%0d aw=%0d, required 3 3",
               wlast_cnt - wl0, aw_cnt - aw0);
    end
  endtask

  task automatic test_outstanding();
    int aw0 = aw_cnt;
    int wl0 = wlast_cnt;
    int nb = b_seen;
    int n = 0;
    b_en = 0;
    m_awready = 1'b1;
    m_wready = 1'b1;
    for (int i = 0; i < 160; i++)
      drive(i < 10, 32'h1000_0000 + 32'(i * 128),
            1'b1, 64'h0A00_0000 + 64'(i), 1'b1);
    repeat (40) tick();
    vectors++;
    if (aw_cnt - aw0 != 8) begin
      miscompares++;
      $display("FAIL os_limit: aw=%0d, required 8", aw_cnt - aw0);
    end
    vectors++;
    if (wlast_cnt - wl0 != 8) begin
      miscompares++;
      $display("FAIL os_bursts: wlast=%0d, required 8", wlast_cnt - wl0);
    end
    vectors++;
    if (m_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL os_awvalid: got %b, required 0", m_awvalid);
    end
    aw_cyc.delete();
    b_cyc.delete();
    b_en = 1;
    while (aw_cnt - aw0 < 10 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (aw_cyc.size() == 0 || b_cyc.size() == 0) begin
      miscompares++;
      $display("FAIL os_resume: aw=%0d b=%0d, required >0 >0",
               aw_cyc.size(), b_cyc.size());
    end else if (aw_cyc[0] - b_cyc[0] != 1) begin
      miscompares++;
      $display("FAIL os_resume: 9th AW %0d cycles after B, required 1",
               aw_cyc[0] - b_cyc[0]);
    end
    wait_done(nb + 10, "os");
    vectors++;
    if (wlast_cnt - wl0 != 10) begin
      miscompares++;
      $display("FAIL os_total: wlast=%0d, required 10", wlast_cnt - wl0);
    end
  endtask

  task automatic test_overflow();
    int nb = b_seen;
    b_en = 1;
    m_awready = 1'b1;
    m_wready = 1'b0;
    for (int i = 0; i < 64; i++)
      drive(i % 16 == 0, 32'h0FA0_0000 + 32'(i * 8),
            1'b1, 64'hC000_0000 + 64'(i), 1'b1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early: got %b after 64 words, required 0", overflow);
    end
    drive(1'b0, '0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got %b after word 65, required 1", overflow);
    end
    m_wready = 1'b1;
    wait_done(nb + 4, "ovf");
    vectors++;
    if (overflow !== 1'b1 || exp_w.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_sticky: ovf=%b left=%0d, required 1 0",
               overflow, exp_w.size());
    end
  endtask

  task automatic test_error_response();
    int nb;
    do_reset();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL err_ovf_clr: got %b, required 0", overflow);
    end
    b_err_idx = 0;
    b_en = 1;
    m_awready = 1'b1;
    m_wready = 1'b1;
    nb = b_seen;
    push_burst(32'h0F80_1000, 64'hE000);
    push_burst(32'h0F80_1080, 64'hE100);
    wait_done(nb + 2, "err");
    vectors++;
    if (bresp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %b, required 1", bresp_err);
    end
    repeat (5) tick();
    vectors++;
    if (bresp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", bresp_err);
    end
    b_err_idx = -1;
    do_reset();
    vectors++;
    if (bresp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clr: got %b, required 0", bresp_err);
    end
  endtask

  task automatic test_mid_burst_reset();
    int n = 0;
    b_en = 1;
    m_awready = 1'b1;
    m_wready = 1'b1;
    push_burst(32'h0F80_2000, 64'hD000);
    while (w_beats < 7 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (w_beats != 7) begin
      miscompares++;
      $display("FAIL mid_reach: beats=%0d, required 7", w_beats);
    end
    sys_rst = 1'b1;
    tick();
    vectors++;
    if (m_wvalid !== 1'b0 || m_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_valid: wvalid=%b awvalid=%b, required 0 0",
               m_wvalid, m_awvalid);
    end
    vectors++;
    if (idle !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_state: idle=%b ovf=%b, required 1 0",
               idle, overflow);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int wl0 = wlast_cnt;
    int nb = b_seen;
    m_awready = 1'b1;
    m_wready = 1'b1;
    b_en = 1;
    push_burst(32'h0F80_3000, 64'hF000);
    push_burst(32'h0F80_3080, 64'hF100);
    wait_done(nb + 2, "b2b");
    vectors++;
    if (wlast_cnt - wl0 != 2 || exp_w.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_counts: wlast=%0d left=%0d, required 2 0",
               wlast_cnt - wl0, exp_w.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_burst(32'h0F80_0000, 64'd0, "basic");
    test_backpressure();
    test_outstanding();
    test_overflow();
    test_error_response();
    test_mid_burst_reset();
    test_basic_burst(32'h0F80_4000, 64'hA500, "post_rst");
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_hp_burst_writer.md
Name: axi_hp_burst_writer

Overview:
- Downstream of the frame address generator in the sensor-to-DRAM write path.
- Consumes a 32-bit burst start address (pulsed once per 16-beat burst) and a 64-bit data beat stream.
- Buffers both streams and drives an AXI3 write master (AW/W/B channels) toward a Zynq HP port.
- Upstream has no backpressure, so this block buffers internally and flags overflow instead of stalling.

Parameters:
- DATA_DEPTH, 64, data FIFO depth in 64-bit words; power of two, at least 32.
- ADDR_DEPTH, 4, address FIFO depth in entries; power of two.
- MAX_OUTSTANDING, 8, maximum number of AW handshakes awaiting a B response.
- BURST_LEN, 16, beats per burst; sets awlen = BURST_LEN-1.

Ports:
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous, active-high reset
- addr_in  in  32  burst start address, byte-addressed, 128-byte aligned
- addr_in_valid  in  1  one-cycle strobe that captures addr_in
- data_in  in  64  data beat
- data_in_valid  in  1  data_in is valid this cycle
- m_awaddr  out  32  AXI write address
- m_awlen  out  4  constant BURST_LEN-1
- m_awsize  out  3  constant 3'b011 (8 bytes)
- m_awburst  out  2  constant 2'b01 (INCR)
- m_awvalid  out  1  address valid
- m_awready  in  1  address ready
- m_wdata  out  64  write data
- m_wstrb  out  8  constant 8'hFF
- m_wlast  out  1  last beat of burst
- m_wvalid  out  1  data valid
- m_wready  in  1  data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  response valid
- m_bready  out  1  response ready; held at 1 after reset
- overflow  out  1  sticky: a data word or an address was dropped
- bresp_err  out  1  sticky: a response with bresp != 0 was received
- idle  out  1  both FIFOs empty, no W burst in progress, outstanding == 0

Behaviour:
- Reset:
  - Both FIFOs are flushed.
  - m_awvalid, m_wvalid, m_wlast, overflow and bresp_err are 0; m_bready is 1; beat counter, granted count and outstanding count are 0.
  - m_awaddr and m_wdata are don't-care while their valid is low.
  - Reset mid-burst abandons the burst; the AXI slave is assumed to be reset together with this block.
- Input capture:
  - An addr_in_valid cycle pushes addr_in into the address FIFO.
  - A data_in_valid cycle pushes data_in into the data FIFO.
  - A push into a full FIFO drops the value and sets overflow. overflow clears only on reset.
  - Simultaneous address and data pushes are independent of each other.
- AW channel:
  - m_awvalid = address FIFO not empty AND outstanding < MAX_OUTSTANDING; m_awaddr = FIFO head.
  - On m_awvalid && m_awready: pop the address FIFO, increment outstanding, increment granted.
  - The handshake sits on registered FIFO output, so the first m_awvalid comes 1 cycle after the push.
- W channel:
  - States are W_IDLE and W_BURST.
  - W_IDLE -> W_BURST when granted > 0 AND data FIFO count >= BURST_LEN. On entry, decrement granted.
  - This guarantees whole bursts with no mid-burst bubbles caused by upstream.
  - In W_BURST: m_wvalid = 1; the beat counter advances on each m_wvalid && m_wready, which also pops the data FIFO.
  - m_wlast = (beat == BURST_LEN-1). After the last handshake, return to W_IDLE with beat = 0.
  - Data never leads its address: W beats of burst N start only after AW handshake N.
- B channel:
  - On m_bvalid, decrement outstanding.
  - If m_bresp != 0, set bresp_err (sticky).
- Simultaneous events:
  - An AW handshake and a B response in the same cycle leave outstanding unchanged.
  - Grant increment and W-start decrement in the same cycle leave granted unchanged.
  - A push and a pop on a FIFO in the same cycle are legal when the FIFO is full: the pop frees the slot, so no overflow.
- Widths:
  - outstanding and granted are clog2(MAX_OUTSTANDING)+1 bits.
  - FIFO count is clog2(DEPTH)+1 bits.
  - The beat counter is 4 bits and wraps at BURST_LEN-1.

Optional Feature:
- Macro: AXI_HP_BURST_WRITER_STATS_EN.
- When defined, adds three 32-bit output ports, all zero on reset and wrapping modulo 2^32:
  - stat_bursts: count of B responses.
  - stat_dropped_words: count of data words dropped on full FIFO.
  - stat_max_fill: high-water mark of the data FIFO count.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds: AXI constants (AXI_BURST_INCR, AXI_SIZE_8B, AXI_RESP_OKAY), the W-state enum, and the default BURST_LEN.
- One sub-module, sync_fifo: parameterised width and depth, push/pop, full/empty/count, registered output.
- sync_fifo is instantiated twice: 32-bit address FIFO and 64-bit data FIFO.

Test Plan:
- Basic burst:
  - Stimulus: address 0x0F800000, then 16 beats 0..15; awready and wready held at 1.
  - Required: one AW with awaddr=0x0F800000 and awlen=15; 16 W beats in order with wlast on beat 15; after bvalid, idle=1.
- Backpressure:
  - Stimulus: 3 bursts queued; wready toggles 1/0 every cycle; awready low for 10 cycles.
  - Required: no W beat before its AW; data order preserved; exactly 3 wlast pulses.
- Outstanding limit:
  - Stimulus: 10 addresses pushed with bvalid held low (this needs ADDR_DEPTH=16 for the run).
  - Required: exactly 8 AW handshakes; the 9th AW is issued 1 cycle after the first bvalid.
- Overflow:
  - Stimulus: wready=0; 65 data words with DATA_DEPTH=64.
  - Required: overflow rises on word 65; the first 64 words are later written unchanged.
- Error response:
  - Stimulus: bresp=2'b10 on one response.
  - Required: bresp_err=1 and stays 1 until sys_rst.
- Mid-burst reset:
  - Stimulus: assert sys_rst on beat 7.
  - Required: next cycle wvalid=0, awvalid=0, idle=1, overflow=0.
